mult_share_arb: RTL and testbench
=================================

# mult_share_arb

Round-robin arbiter that shares one 4x4 Braun array multiplier (`ArrayMult`, combinational, 8-bit product) among 2**IDW requesters. Each requester presents an operand pair with a valid/ready handshake. The arbiter grants one request at a time, registers the operands into the multiplier, and captures the product. It returns the product with the requester's index over a valid/ready response channel. The block sits between the requesting datapath units and the single shared multiplier instance, which it instantiates internally.

## Interface
- IDW, 2, requester-index width; NREQ = 2**IDW requesters (IDW 1..4 supported)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  NREQ  per-requester request valid
- req_ready  output  NREQ  per-requester grant/accept, at most one bit high
- req_a  input  4*NREQ  operand a; requester i uses bits [4i+3:4i]
- req_b  input  4*NREQ  operand b, same packing
- resp_valid  output  1  product available
- resp_ready  input  1  consumer accepts product
- resp_p  output  8  product a*b (unsigned)
- resp_id  output  IDW  index of requester that owns resp_p
- busy  output  1  high in any state other than IDLE
- ops_done  output  16  count of completed responses, wraps 65535->0

## Operation
- FSM states: IDLE, CALC, STAGE (only with MULT_PIPE_EN), RESP.
- IDLE:
  - If any req_valid is high, pick the winner g by round-robin. The search starts at (last_grant+1) mod NREQ, ascending with wrap.
  - req_ready[g]=1 combinationally in the same cycle. All other req_ready bits are 0.
  - On the clock edge: a_reg<=req_a[g], b_reg<=req_b[g], id_reg<=g, last_grant<=g, go to CALC.
  - With no req_valid high, stay in IDLE and keep all req_ready at 0.
- CALC: the multiplier is driven from a_reg/b_reg.
  - Without pipe: p_reg<=mult output, go to RESP.
  - With pipe: a register samples the mult output, go to STAGE.
- STAGE: p_reg<=stage register, go to RESP.
- RESP: resp_valid=1, resp_p=p_reg, resp_id=id_reg.
  - Hold all response outputs stable until resp_ready=1.
  - On the edge where resp_valid&resp_ready: ops_done<=ops_done+1 and go to IDLE.
- req_ready is 0 in CALC, STAGE and RESP. Only one operation is in flight at a time.
- Requester signals are only sampled in IDLE. A requester may deassert req_valid while ungranted with no effect on arbiter state.
- Arithmetic: resp_p is the full 8-bit unsigned product, with no truncation. The maximum is 15*15=225.

## Timing
- Reset values: FSM=IDLE, last_grant=NREQ-1 (so requester 0 wins first), a_reg/b_reg/p_reg=0, id_reg=0, resp_valid=0, resp_p=0, resp_id=0, busy=0, ops_done=0. req_ready=0 while rst_n is low.
- Latency:
  - Acceptance happens in cycle 0 (req_valid[g]&req_ready[g]).
  - resp_valid is first high in cycle 2 without the pipe, cycle 3 with MULT_PIPE_EN.
- Throughput: with resp_ready held high, one operation every 3 cycles (4 with the pipe). The earliest next acceptance is the cycle after the response handshake.
- Simultaneous requests: exactly one grant per IDLE cycle, in round-robin order. No requester waits more than NREQ-1 grants.
- resp_ready low in RESP: the FSM stalls indefinitely with outputs frozen, and ops_done does not change.
- Reset asserted mid-operation: the in-flight operation is discarded and no response is issued. All state returns to reset values asynchronously.
- ops_done wraps at 16 bits with no saturation.

## Configuration
- MULT_PIPE_EN:
  - Defined: adds a register stage between multiplier output and p_reg (STAGE state). Latency rises to 3 cycles and the repeat rate to 4 cycles.
  - Undefined: the STAGE state and its register are absent. Latency is 2 cycles and the repeat rate 3 cycles.
  - Functional results are identical in both builds.

## Test plan
- Reset: drive rst_n=0 with all req_valid=1. Required: req_ready=0, resp_valid=0, ops_done=0, busy=0. After release, requester 0 is granted first.
- Single op: requester 2 presents a=13, b=11 with resp_ready=1. Required: req_ready=4'b0100 in cycle 0, then resp_valid=1 with resp_p=143 and resp_id=2 in cycle 2 (cycle 3 with MULT_PIPE_EN), and ops_done=1.
- Round-robin: all four requesters valid continuously, with a=i+1, b=15. Required grant order 0,1,2,3,0. Products are 15, 30, 45, 60, 15 with matching resp_id.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP. Required: resp_p and resp_id stable, req_ready=0 throughout, ops_done unchanged until the handshake.
- Reset mid-op: assert rst_n=0 during CALC. Required: no resp_valid is ever issued for that op, and the FSM is in IDLE on release.
- Extremes and wrap: run a=15, b=15 and get resp_p=225; run a=0, b=9 and get resp_p=0. Preload ops_done to 65535 by running ops, then complete one more: required ops_done=0.

Source files
------------

// File: rtl/mult_share_arb.sv
// Round-robin arbiter sharing one 4x4 Braun array multiplier among 2**IDW requesters.
// Define MULT_PIPE_EN to add a register stage (STAGE state) after the multiplier output.

module ArrayMult (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [4:0] row;
  logic [4:0] nxt;
  logic       cy;
  logic       x;
  logic       y;

  // Rows of ripple full adders; each row retires one low product bit.
  always_comb begin
    p   = '0;
    nxt = '0;
    cy  = 1'b0;
    x   = 1'b0;
    y   = 1'b0;
    row = {1'b0, a & {4{b[0]}}};
    for (int i = 1; i < 4; i++) begin
      p[i-1] = row[0];
      cy     = 1'b0;
      for (int j = 0; j < 4; j++) begin
        x      = row[j+1];
        y      = a[j] & b[i];
        nxt[j] = x ^ y ^ cy;
        cy     = (x & y) | (x & cy) | (y & cy);
      end
      nxt[4] = cy;
      row    = nxt;
    end
    p[7:3] = row;
  end
endmodule

module mult_share_arb #(
  parameter int IDW = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [(1<<IDW)-1:0]    req_valid,
  output logic [(1<<IDW)-1:0]    req_ready,
  input  logic [4*(1<<IDW)-1:0]  req_a,
  input  logic [4*(1<<IDW)-1:0]  req_b,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [7:0]             resp_p,
  output logic [IDW-1:0]         resp_id,
  output logic                   busy,
  output logic [15:0]            ops_done
);
  localparam int NREQ = 1 << IDW;

`ifdef MULT_PIPE_EN
  typedef enum logic [1:0] {IDLE, CALC, STAGE, RESP} state_t;
`else
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
`endif

  state_t           state_q, state_d;
  logic [3:0]       a_q, a_d, b_q, b_d;
  logic [7:0]       p_q, p_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   last_grant_q, last_grant_d;
  logic [15:0]      ops_done_q, ops_done_d;
  logic             resp_valid_q, resp_valid_d;
  logic             busy_q, busy_d;
  logic [7:0]       mult_p;
  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic [IDW-1:0]   cand;
`ifdef MULT_PIPE_EN
  logic [7:0]       stage_q, stage_d;
`endif

  ArrayMult u_mult (
    .a (a_q),
    .b (b_q),
    .p (mult_p)
  );

  // First valid requester at or after last_grant+1, wrapping naturally in IDW bits.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = last_grant_q + IDW'(k + 1);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
    assign req_ready[gi] = rst_n && (state_q == IDLE) && grant_found && (grant_idx == IDW'(gi));
  end

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    p_d          = p_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    ops_done_d   = ops_done_q;
    resp_valid_d = resp_valid_q;
`ifdef MULT_PIPE_EN
    stage_d      = stage_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          a_d          = req_a[{grant_idx, 2'b00} +: 4];
          b_d          = req_b[{grant_idx, 2'b00} +: 4];
          id_d         = grant_idx;
          last_grant_d = grant_idx;
          state_d      = CALC;
        end
      end
      CALC: begin
`ifdef MULT_PIPE_EN
        stage_d      = mult_p;
        state_d      = STAGE;
`else
        p_d          = mult_p;
        resp_valid_d = 1'b1;
        state_d      = RESP;
`endif
      end
`ifdef MULT_PIPE_EN
      STAGE: begin
        p_d          = stage_q;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
`endif
      RESP: begin
        if (resp_ready) begin
          ops_done_d   = ops_done_q + 16'd1;
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      p_q          <= '0;
      id_q         <= '0;
      last_grant_q <= IDW'(NREQ - 1);
      ops_done_q   <= '0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef MULT_PIPE_EN
      stage_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      p_q          <= p_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      ops_done_q   <= ops_done_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
`ifdef MULT_PIPE_EN
      stage_q      <= stage_d;
`endif
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_p     = p_q;
  assign resp_id    = id_q;
  assign busy       = busy_q;
  assign ops_done   = ops_done_q;
endmodule

// File: tb/tb_mult_share_arb.sv
// Directed self-checking bench for mult_share_arb (IDW=2, four requesters).

module tb_mult_share_arb;
`ifdef MULT_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [7:0]  resp_p;
  logic [1:0]  resp_id;
  logic        busy;
  logic [15:0] ops_done;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] ops_exp  = '0;

  mult_share_arb #(.IDW(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_p     (resp_p),
    .resp_id    (resp_id),
    .busy       (busy),
    .ops_done   (ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [3:0] valid, input logic [15:0] a_bus,
                        input logic [15:0] b_bus, input int exp_id, input int exp_p, input int stall);
    logic [3:0] exp_rdy;
    exp_rdy    = 4'b0001 << exp_id;
    req_valid  = valid;
    req_a      = a_bus;
    req_b      = b_bus;
    resp_ready = (stall == 0);
    #1;
    check_val({tag, ".grant"}, 32'(req_ready), 32'(exp_rdy));
    check_val({tag, ".idle_busy"}, 32'(busy), 32'd0);
    tick();
    check_val({tag, ".calc_busy"}, 32'(busy), 32'd1);
    check_val({tag, ".calc_ready"}, 32'(req_ready), 32'd0);
    check_val({tag, ".calc_valid"}, 32'(resp_valid), 32'd0);
    repeat (LAT - 1) tick();
    check_val({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
    check_val({tag, ".resp_p"}, 32'(resp_p), 32'(exp_p));
    check_val({tag, ".resp_id"}, 32'(resp_id), 32'(exp_id));
    for (int s = 0; s < stall; s++) begin
      tick();
      check_val({tag, ".stall_valid"}, 32'(resp_valid), 32'd1);
      check_val({tag, ".stall_p"}, 32'(resp_p), 32'(exp_p));
      check_val({tag, ".stall_id"}, 32'(resp_id), 32'(exp_id));
      check_val({tag, ".stall_ready"}, 32'(req_ready), 32'd0);
      check_val({tag, ".stall_ops"}, 32'(ops_done), 32'(ops_exp));
    end
    resp_ready = 1'b1;
    tick();
    ops_exp = ops_exp + 16'd1;
    check_val({tag, ".ops_done"}, 32'(ops_done), 32'(ops_exp));
    check_val({tag, ".resp_drop"}, 32'(resp_valid), 32'd0);
    $display("op %s: id=%0d p=%0d ops_done=%0d", tag, resp_id, resp_p, ops_done);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst_n      = 1'b0;
    resp_ready = 1'b1;
    req_valid  = 4'hF;
    req_a      = {4'd4, 4'd3, 4'd2, 4'd1};
    req_b      = 16'hFFFF;
    #1;
    check_val("rst.req_ready", 32'(req_ready), 32'd0);
    check_val("rst.resp_valid", 32'(resp_valid), 32'd0);
    check_val("rst.ops_done", 32'(ops_done), 32'd0);
    check_val("rst.busy", 32'(busy), 32'd0);
    check_val("rst.resp_p", 32'(resp_p), 32'd0);
    check_val("rst.resp_id", 32'(resp_id), 32'd0);
    repeat (3) tick();
    check_val("rst.hold_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;

    // All four valid continuously: grants 0,1,2,3,0.
    for (int k = 0; k < 5; k++) begin
      run_op($sformatf("rr%0d", k), 4'hF, {4'd4, 4'd3, 4'd2, 4'd1}, 16'hFFFF,
             k % 4, ((k % 4) + 1) * 15, 0);
    end

    run_op("single", 4'b0100, 16'h0D00, 16'h0B00, 2, 143, 0);

    // Requester 0 also waits while requester 3 is stalled in RESP.
    run_op("bp", 4'b1001, 16'h7000, 16'h9000, 3, 63, 5);

    req_valid = 4'b0010;
    req_a     = 16'h0050;
    req_b     = 16'h0050;
    #1;
    check_val("midrst.grant", 32'(req_ready), 32'b0010);
    tick();
    check_val("midrst.calc_busy", 32'(busy), 32'd1);
    req_valid = 4'b0000;
    rst_n     = 1'b0;
    #1;
    check_val("midrst.busy", 32'(busy), 32'd0);
    check_val("midrst.valid", 32'(resp_valid), 32'd0);
    check_val("midrst.ops", 32'(ops_done), 32'd0);
    ops_exp = '0;
    tick();
    tick();
    rst_n = 1'b1;
    seen  = 0;
    for (int c = 0; c < LAT + 3; c++) begin
      tick();
      if (resp_valid) seen++;
    end
    check_val("midrst.no_resp", 32'(seen), 32'd0);
    check_val("midrst.idle", 32'(busy), 32'd0);
    $display("op midrst: in-flight op discarded, ops_done=%0d", ops_done);

    run_op("max", 4'b0011, 16'h000F, 16'h009F, 0, 225, 0);
    run_op("zero", 4'b0011, 16'h000F, 16'h009F, 1, 0, 0);
    run_op("mix2", 4'b1100, 16'hC900, 16'hAE00, 2, 126, 0);
    run_op("mix3", 4'b1100, 16'hC900, 16'hAE00, 3, 120, 0);

    req_valid = 4'b0000;
    force dut.ops_done_q = 16'hFFFF;
    #1;
    release dut.ops_done_q;
    ops_exp = 16'hFFFF;
    run_op("wrap", 4'b0001, 16'h0006, 16'h0007, 0, 42, 0);
    check_val("wrap.zero", 32'(ops_done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
